imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/loader_pkg.sv | 36 +++
 rtl/imem_loader_if.sv | 48 ++++
 rtl/imem_loader.sv | 194 +++++++++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared types and constants for the instruction-memory
//                boot loader (state encoding, header size, default depth).
//  Revision    : 1.0  initial release
// ============================================================================
package loader_pkg;

    // Loader FSM states. The header occupies LEN_LO/LEN_HI, image bytes are
    // collected in LOAD, and WRITE is the single-cycle memory strobe.
    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LOAD   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // Number of header bytes carrying the little-endian word count.
    localparam int LEN_BYTES = 2;

    // Default instruction memory capacity in bytes.
    localparam int DEFAULT_DEPTH_BYTES = 256;

    // Bytes per instruction word; image words are assembled from this many bytes.
    localparam int BYTES_PER_WORD = 4;

    // Capacity of the instruction memory in words.
    function automatic int max_words(input int depth_bytes);
        return depth_bytes / BYTES_PER_WORD;
    endfunction

endpackage : loader_pkg
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_if
//  Description : Byte-stream receive handshake plus instruction-memory write
//                port used by the boot loader.
//                master : the loader (accepts bytes, drives the memory port)
//                slave  : the environment (byte source and memory)
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_loader_if
    import loader_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_BYTES = DEFAULT_DEPTH_BYTES
) ();

    localparam int AW = $clog2(DEPTH_BYTES);

    // Upstream byte stream
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;

    // Instruction memory write port
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface : imem_loader_if
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot loader that receives a length-prefixed byte image,
//                assembles little-endian words and writes them into the
//                processor instruction memory, holding the core in reset
//                until the full image has been written.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
    import loader_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int DEPTH_BYTES = DEFAULT_DEPTH_BYTES,
    localparam int MAX_WORDS   = DEPTH_BYTES / BYTES_PER_WORD,
    localparam int AW          = $clog2(DEPTH_BYTES),
    localparam int CW          = $clog2(MAX_WORDS) + 1
) (
    input  wire logic          clock,
    input  wire logic          reset,
    imem_loader_if.master      bus,
    output logic               core_reset,
    output logic               load_done,
    output logic               load_error,
    output logic [CW-1:0]      words_loaded
);

    // Header counts are 16 bits wide; compare them against capacity at that width.
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t           state_q;
    logic [1:0]       byte_cnt_q;
    logic [15:0]      n_q;
    logic [CW-1:0]    words_q;
    logic [WIDTH-1:0] asm_q;

    // Registered outputs
    logic             rx_ready_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic             core_reset_q;
    logic             load_done_q;
    logic             load_error_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             hs;
    logic [WIDTH-1:0] asm_d;
    logic [15:0]      n_full;
    logic [CW-1:0]    words_inc;
    logic             last_word;

    // A byte transfers only when the loader is ready and upstream is valid.
    assign hs        = bus.rx_valid & rx_ready_q;

    // Full word count as it will be once the high header byte is captured.
    assign n_full    = {bus.rx_data, n_q[7:0]};

    // Count after the current WRITE completes; the image is finished when it
    // reaches the header count.
    assign words_inc = words_q + CW'(1);
    assign last_word = (16'(words_inc) == n_q);

    // Insert the incoming byte into lane byte_cnt of the assembly register.
    always_comb begin
        asm_d                            = asm_q;
        asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
    end

    // Loader FSM: header parsing, word assembly, write strobe and status flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_LEN_LO;
            byte_cnt_q   <= 2'd0;
            n_q          <= 16'd0;
            words_q      <= '0;
            asm_q        <= '0;
            rx_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            // The write strobe is a single-cycle pulse raised only on entry to WRITE.
            mem_we_q <= 1'b0;

            unique case (state_q)
                ST_LEN_LO: begin
                    if (hs) begin
                        n_q[7:0] <= bus.rx_data;
                        state_q  <= ST_LEN_HI;
                    end
                end

                ST_LEN_HI: begin
                    if (hs) begin
                        n_q[15:8] <= bus.rx_data;
                        if (n_full == 16'd0) begin
                            // Empty image: release the core immediately.
                            state_q      <= ST_DONE;
                            rx_ready_q   <= 1'b0;
                            load_done_q  <= 1'b1;
                            core_reset_q <= 1'b0;
                        end else if (n_full > MAX_N) begin
                            // Image cannot fit: lock up with the core held in reset.
                            state_q      <= ST_ERROR;
                            rx_ready_q   <= 1'b0;
                            load_error_q <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (hs) begin
                        asm_q      <= asm_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Fourth byte: present the word to memory next cycle.
                            // Capacity checks guarantee words_q*4 fits in AW bits.
                            state_q     <= ST_WRITE;
                            rx_ready_q  <= 1'b0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= AW'({words_q, 2'b00});
                            mem_wdata_q <= asm_d;
                        end
                    end
                end

                ST_WRITE: begin
                    words_q <= words_inc;
                    if (last_word) begin
                        state_q      <= ST_DONE;
                        load_done_q  <= 1'b1;
                        core_reset_q <= 1'b0;
                    end else begin
                        state_q    <= ST_LOAD;
                        rx_ready_q <= 1'b1;
                    end
                end

                ST_DONE, ST_ERROR: begin
                    // Terminal until reset; all outputs hold.
                end

                default: begin
                    // Unreachable encodings recover to a safe restart with the core held.
                    state_q      <= ST_LEN_LO;
                    rx_ready_q   <= 1'b1;
                    core_reset_q <= 1'b1;
                    load_done_q  <= 1'b0;
                    load_error_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.rx_ready  = rx_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign core_reset    = core_reset_q;
    assign load_done     = load_done_q;
    assign load_error    = load_error_q;
    assign words_loaded  = words_q;

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    a_done_err_exclusive : assert property (@(posedge clock) disable iff (!reset)
        !(load_done_q && load_error_q));

    a_no_accept_during_write : assert property (@(posedge clock) disable iff (!reset)
        mem_we_q |-> !rx_ready_q);

    a_word_aligned : assert property (@(posedge clock) disable iff (!reset)
        mem_we_q |-> (mem_addr_q[1:0] == 2'b00));

    a_core_released_only_done : assert property (@(posedge clock) disable iff (!reset)
        !core_reset_q |-> load_done_q);

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;
    import loader_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int CW    = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.WIDTH(WIDTH), .DEPTH_BYTES(DEPTH)) bus ();

    logic          core_reset;
    logic          load_done;
    logic          load_error;
    logic [CW-1:0] words_loaded;

    imem_loader #(.WIDTH(WIDTH), .DEPTH_BYTES(DEPTH)) dut (
        .clock        (clk),
        .reset        (rst_n),
        .bus          (bus.master),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    int checks = 0;
    int errors = 0;

    // Log of every memory write seen on a rising edge
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    int            ready_viol = 0;

    always @(posedge clk) begin
        if (rst_n && bus.mem_we) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_wdata);
            if (bus.rx_ready) ready_viol++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        log_addr.delete();
        log_data.delete();
        ready_viol = 0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns 1 ns after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        for (int g = 0; g < gap; g++) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (!bus.rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: rx_ready stayed %0b, required 1", bus.rx_ready);
            bus.rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b expected 1", bus.rx_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h expected 00", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b expected 1", core_reset); end
        checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin errors++; $display("FAIL reset_flags: got done=%b err=%b expected 0 0", load_done, load_error); end
        checks++; if (words_loaded !== 7'd0) begin errors++; $display("FAIL reset_words: got %0d expected 0", words_loaded); end
    endtask

    task automatic test_two_words();
        logic [7:0] s [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(s[i], 0);
        // One cycle after the 4th byte of word 2: WRITE
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h04) begin errors++; $display("FAIL two_latency: got we=%b addr=%h expected 1 04", bus.mem_we, bus.mem_addr); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL two_done_early: got %b expected 0", load_done); end
        @(posedge clk); #1;
        checks++; if (load_done !== 1'b1 || core_reset !== 1'b0) begin errors++; $display("FAIL two_done: got done=%b core_reset=%b expected 1 0", load_done, core_reset); end
        checks++; if (words_loaded !== 7'd2) begin errors++; $display("FAIL two_words_loaded: got %0d expected 2", words_loaded); end
        checks++; if (bus.mem_we !== 1'b0 || bus.rx_ready !== 1'b0) begin errors++; $display("FAIL two_done_outputs: got we=%b ready=%b expected 0 0", bus.mem_we, bus.rx_ready); end
        checks++;
        if (log_addr.size() != 2) begin
            errors++; $display("FAIL two_write_count: got %0d expected 2", log_addr.size());
        end else if (log_addr[0] !== 8'h00 || log_data[0] !== 32'h00A00513 ||
                     log_addr[1] !== 8'h04 || log_data[1] !== 32'h0000006F) begin
            errors++; $display("FAIL two_write_data: got %h:%h %h:%h expected 00:00a00513 04:0000006f",
                               log_addr[0], log_data[0], log_addr[1], log_data[1]);
        end
    endtask

    task automatic test_empty();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++; if (load_done !== 1'b1 || core_reset !== 1'b0 || bus.rx_ready !== 1'b0) begin errors++; $display("FAIL empty_done: got done=%b core_reset=%b ready=%b expected 1 0 0", load_done, core_reset, bus.rx_ready); end
        repeat (4) @(negedge clk);
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL empty_writes: got %0d expected 0", log_addr.size()); end
    endtask

    task automatic test_error();
        do_reset();
        send_byte(8'h41, 0);
        send_byte(8'h00, 1);
        checks++; if (load_error !== 1'b1 || bus.rx_ready !== 1'b0 || core_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL error_flags: got err=%b ready=%b core_reset=%b done=%b expected 1 0 1 0", load_error, bus.rx_ready, core_reset, load_done); end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.rx_data = 8'(i * 37);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        checks++; if (log_addr.size() != 0 || words_loaded !== 7'd0 || load_error !== 1'b1) begin errors++; $display("FAIL error_ignore: got writes=%0d words=%0d err=%b expected 0 0 1", log_addr.size(), words_loaded, load_error); end
    endtask

    task automatic test_full();
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp_w;
        logic [7:0]  exp_a;
        int          bad;
        do_reset();
        send_byte(8'h40, $urandom_range(0, 2));
        send_byte(8'h00, $urandom_range(0, 2));
        for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A, $urandom_range(0, 2));
        @(posedge clk); #1;
        checks++; if (load_done !== 1'b1 || words_loaded !== 7'd64) begin errors++; $display("FAIL full_done: got done=%b words=%0d expected 1 64", load_done, words_loaded); end
        checks++; if (log_addr.size() != 64) begin errors++; $display("FAIL full_write_count: got %0d expected 64", log_addr.size()); end
        bad = 0;
        for (int k = 0; k < 64 && k < log_addr.size(); k++) begin
            b0    = 8'(4 * k)     ^ 8'h5A;
            b1    = 8'(4 * k + 1) ^ 8'h5A;
            b2    = 8'(4 * k + 2) ^ 8'h5A;
            b3    = 8'(4 * k + 3) ^ 8'h5A;
            exp_w = {b3, b2, b1, b0};
            exp_a = 8'(4 * k);
            if (log_addr[k] !== exp_a || log_data[k] !== exp_w) begin
                if (bad < 4) $display("FAIL full_word%0d: got %h:%h expected %h:%h", k, log_addr[k], log_data[k], exp_a, exp_w);
                bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_words: got %0d bad words expected 0", bad); end
        checks++; if (log_addr.size() == 64 && log_addr[63] !== 8'hFC) begin errors++; $display("FAIL full_last_addr: got %h expected fc", log_addr[63]); end
        checks++; if (ready_viol != 0) begin errors++; $display("FAIL full_ready_in_write: got %0d expected 0", ready_viol); end
        // Reset after a load must clear the registered write port
        do_reset();
        checks++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0 || words_loaded !== 7'd0) begin errors++; $display("FAIL full_reload_reset: got addr=%h data=%h words=%0d expected 00 0 0", bus.mem_addr, bus.mem_wdata, words_loaded); end
    endtask

    task automatic test_abort();
        logic [7:0] s [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (bus.rx_ready !== 1'b1 || words_loaded !== 7'd0 || core_reset !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL abort_state: got ready=%b words=%0d core_reset=%b done=%b expected 1 0 1 0", bus.rx_ready, words_loaded, core_reset, load_done); end
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL abort_writes: got %0d expected 0", log_addr.size()); end
        for (int i = 0; i < 6; i++) send_byte(s[i], 0);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL abort_reload: got we=%b addr=%h data=%h expected 1 00 deadbeef", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        @(posedge clk); #1;
        checks++; if (load_done !== 1'b1 || words_loaded !== 7'd1) begin errors++; $display("FAIL abort_done: got done=%b words=%0d expected 1 1", load_done, words_loaded); end
    endtask

    task automatic test_reset_dominates();
        do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h05;
        @(negedge clk);
        rst_n        = 1'b1;
        bus.rx_valid = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++; if (load_done !== 1'b1 || load_error !== 1'b0) begin errors++; $display("FAIL reset_drop_byte: got done=%b err=%b expected 1 0", load_done, load_error); end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_two_words();
        test_empty();
        test_error();
        test_full();
        test_abort();
        test_reset_dominates();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
